// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, code memory port and IF/ID slot.
// master = fetch stage, slave = surrounding pipeline and code memory.
interface instr_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        fetch_err;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  instr_in,
    output pc_out,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid,
    output fetch_err
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_pc,
    output instr_in,
    input  pc_out,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid,
    input  fetch_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN FSM, IF/ID slot, redirect.
// Define IFETCH_PERF_EN to add fetch_count/stall_count outputs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned CODE_DEPTH = 256,
  parameter logic [31:0] BUBBLE     = 32'hFFFF_FFFF
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] MASK  = 32'(CODE_DEPTH - 1);
  localparam logic [31:0] DEPTH = 32'(CODE_DEPTH);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  assign bus.pc_out      = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_err   = err_q;

  // Redirect wins over both BOOT and stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (bus.redirect_valid) begin
      state_d = RUN;
      pc_d    = bus.redirect_pc & MASK;
      instr_d = BUBBLE;
      ifpc_d  = '0;
      valid_d = 1'b0;
      err_d   = err_q | (bus.redirect_pc >= DEPTH);
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if (!bus.stall) begin
      pc_d    = (pc_q + 32'd1) & MASK;
      instr_d = bus.instr_in;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic        fetch_go;
  logic        stall_hit;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  assign fetch_go  = (state_q == RUN) & ~bus.redirect_valid & ~bus.stall;
  assign stall_hit = (state_q == RUN) & ~bus.redirect_valid & bus.stall;

  always_comb begin
    fcnt_d = fcnt_q + {31'd0, fetch_go};
    scnt_d = scnt_q + {31'd0, stall_hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver pushes model predictions,
// monitor pops and compares one slot per clock.
module tb_instr_fetch;
  localparam int unsigned DEPTH  = 256;
  localparam logic [31:0] RST_PC = 32'd0;
  localparam logic [31:0] BUB    = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        valid;
    logic        err;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [31:0] mem [DEPTH];

  int unsigned m_pc;
  bit          m_boot;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_fc;
  logic [31:0] m_sc;

  instr_fetch_if bus();

`ifdef IFETCH_PERF_EN
  logic [31:0] fc;
  logic [31:0] sc;
`endif

  instr_fetch #(
    .RESET_PC(RST_PC),
    .CODE_DEPTH(DEPTH),
    .BUBBLE(BUB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count(fc),
    .stall_count(sc)
`endif
  );

  always #5 clk = ~clk;

  assign bus.instr_in = mem[bus.pc_out[7:0]];

  task automatic cmp(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_boot  = 1'b1;
    m_instr = BUB;
    m_ifpc  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_fc    = '0;
    m_sc    = '0;
  endtask

  // Drive one cycle and predict the IF/ID slot after the coming edge.
  task automatic step(input logic st, input logic rv,
                      input logic [31:0] rp);
    exp_t e;
    @(negedge clk);
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    if (rv) begin
      if (rp >= DEPTH) m_err = 1'b1;
      m_pc    = rp % DEPTH;
      m_instr = BUB;
      m_ifpc  = '0;
      m_valid = 1'b0;
      m_boot  = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (st) begin
      m_sc = m_sc + 1;
    end else begin
      m_instr = mem[m_pc];
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = (m_pc + 1) % DEPTH;
      m_fc    = m_fc + 1;
    end
    e.pc    = m_pc;
    e.instr = m_instr;
    e.ifpc  = m_ifpc;
    e.valid = m_valid;
    e.err   = m_err;
    e.fc    = m_fc;
    e.sc    = m_sc;
    sb.push_back(e);
    chk_en = 1'b1;
  endtask

  // Reset is asserted between edges; outputs must settle without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    cmp("rst_pc", bus.pc_out, RST_PC);
    cmp("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    cmp("rst_instr", bus.if_id_instr, BUB);
    cmp("rst_ifpc", bus.if_id_pc, 32'd0);
    cmp("rst_err", {31'd0, bus.fetch_err}, 32'd0);
`ifdef IFETCH_PERF_EN
    cmp("rst_fc", fc, 32'd0);
    cmp("rst_sc", sc, 32'd0);
`endif
    sb.delete();
    model_reset();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (chk_en) begin
      if (sb.size() == 0) begin
        cmp("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        cmp("pc_out", bus.pc_out, e.pc);
        cmp("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        cmp("if_id_instr", bus.if_id_instr, e.instr);
        cmp("if_id_pc", bus.if_id_pc, e.ifpc);
        cmp("fetch_err", {31'd0, bus.fetch_err}, {31'd0, e.err});
`ifdef IFETCH_PERF_EN
        cmp("fetch_count", fc, e.fc);
        cmp("stall_count", sc, e.sc);
`endif
      end
    end
  end

  initial begin
    logic        st;
    logic        rv;
    logic [31:0] rp;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'(i + 100);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();

    // BOOT edge then free run
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
    // IF/ID holds pc 3 here: stall two cycles then release
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    // redirect beats stall, one bubble
    step(1'b1, 1'b1, 32'd8);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    // wrap at end of code memory
    step(1'b0, 1'b1, 32'd254);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
    // back-to-back redirects, out-of-range target
    step(1'b0, 1'b1, 32'd300);
    step(1'b0, 1'b1, 32'd10);
    step(1'b1, 1'b1, 32'd20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
    // redirect during BOOT
    do_reset();
    step(1'b0, 1'b1, 32'd50);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(99) < 12);
      st = ($urandom_range(99) < 30);
      if ($urandom_range(9) == 0) rp = $urandom;
      else rp = 32'($urandom_range(DEPTH - 1));
      step(st, rv, rp);
    end
    // async reset mid-stall at PC=5, then restart
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);

    @(posedge clk);
    #2;
    chk_en = 1'b0;
    cmp("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 0: word address fetched first after reset.
REQ-002 Parameter CODE_DEPTH, default 256: code memory depth in 32-bit words; power of two.
REQ-003 Parameter BUBBLE, default 32'hFFFF_FFFF: instruction word driven into IF/ID when the slot is invalid.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 stall  input  1  hazard-unit hold request (e.g. load-use); freezes PC and IF/ID.
REQ-007 redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-008 redirect_pc  input  32  word-addressed redirect target.
REQ-009 pc_out  output  32  word address to code memory; combinational from PC register.
REQ-010 instr_in  input  32  combinational instruction read of code memory at pc_out.
REQ-011 if_id_instr  output  32  registered fetched instruction.
REQ-012 if_id_pc  output  32  registered address of if_id_instr.
REQ-013 if_id_valid  output  1  if_id_instr is a real instruction; downstream ignores slot when 0.
REQ-014 fetch_err  output  1  sticky: an out-of-range redirect target was received.

Function
REQ-015 pc_out SHALL equal the PC register at all times, with no added latency; instr_in is sampled in the same cycle.
REQ-016 FSM states SHALL be BOOT and RUN; reset enters BOOT.
REQ-017 BOOT SHALL last exactly one clock after rst_n deasserts, then go to RUN; in BOOT, PC SHALL hold and if_id_valid SHALL stay 0.
REQ-018 In RUN with redirect_valid=0 and stall=0, each edge SHALL load if_id_instr<=instr_in, if_id_pc<=PC and if_id_valid<=1, and set PC<=(PC+1) mod CODE_DEPTH.
REQ-019 PC SHALL wrap from CODE_DEPTH-1 to 0 with no error.
REQ-020 In RUN with stall=1 and redirect_valid=0, PC, if_id_instr, if_id_pc and if_id_valid SHALL all hold their values.
REQ-021 redirect_valid=1 SHALL take priority over stall and over BOOT on the same edge.
REQ-022 On a redirect edge: PC<=redirect_pc mod CODE_DEPTH, if_id_valid<=0, if_id_instr<=BUBBLE, if_id_pc<=0, and the state SHALL become RUN.
REQ-023 The instruction fetched at the redirect target SHALL appear in IF/ID one edge after the redirect edge (one-bubble penalty).
REQ-024 fetch_err SHALL set on any redirect edge with redirect_pc >= CODE_DEPTH and SHALL hold until reset; the truncated target is still used.
REQ-025 Back-to-back redirects SHALL each reload PC; if_id_valid SHALL stay 0 throughout.

Reset
REQ-026 While rst_n=0, outputs SHALL be: PC=RESET_PC, if_id_valid=0, if_id_instr=BUBBLE, if_id_pc=0, fetch_err=0, state=BOOT; all counters 0.
REQ-027 A reset asserted mid-operation SHALL override any stall or redirect in flight and take effect immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro IFETCH_PERF_EN, when defined, SHALL add outputs fetch_count[31:0] and stall_count[31:0].
REQ-029 fetch_count SHALL increment on each edge that loads if_id_valid<=1.
REQ-030 stall_count SHALL increment on each RUN edge with stall=1 and redirect_valid=0.
REQ-031 Both counters SHALL wrap at 2^32.
REQ-032 Without IFETCH_PERF_EN, neither port nor counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then a free run with memory[i]=i+100 -> one edge of BOOT with valid=0, then IF/ID shows pc 0,1,2,... with instr 100,101,102,... and valid=1 on each edge.
REQ-034 stall=1 for 2 cycles while IF/ID holds pc 3 -> IF/ID stays pc 3 and pc_out stays 4 for both cycles; on release, pc 4 is issued; stall_count=2 if enabled.
REQ-035 redirect_valid=1 with stall=1 and redirect_pc=8 -> next edge valid=0 and instr=FFFFFFFF; the following edge gives IF/ID pc 8 with valid=1.
REQ-036 Free run from PC=254 with CODE_DEPTH=256 -> issues pc 254, 255, 0, 1; fetch_err stays 0.
REQ-037 Redirect to 300 -> PC=44 and fetch_err=1, which persists across further redirects until rst_n=0.
REQ-038 rst_n pulled low asynchronously mid-stall at PC=5 -> outputs reach reset values before the next edge; on release, fetch restarts at RESET_PC after BOOT.
